// File: rtl/eth_tx_arbiter_if.sv
// eth_tx_arbiter_if: two byte-stream sources plus the eth_packet_former byte port and arbiter status.
interface eth_tx_arbiter_if;
    logic       S0_Valid;
    logic [7:0] S0_Data;
    logic       S0_Last;
    logic       S0_Ready;
    logic       S1_Valid;
    logic [7:0] S1_Data;
    logic       S1_Last;
    logic       S1_Ready;
    logic       Dat_Rdy;
    logic       Tx_En;
    logic       Dat_En;
    logic [7:0] Data;
    logic       Data_Last;
    logic [1:0] Grant;
    logic       Busy;
    logic       Trunc_Err;

    modport master (
        input  S0_Valid, S0_Data, S0_Last, S1_Valid, S1_Data, S1_Last, Dat_Rdy, Tx_En,
        output S0_Ready, S1_Ready, Dat_En, Data, Data_Last, Grant, Busy, Trunc_Err
    );

    modport slave (
        output S0_Valid, S0_Data, S0_Last, S1_Valid, S1_Data, S1_Last, Dat_Rdy, Tx_En,
        input  S0_Ready, S1_Ready, Dat_En, Data, Data_Last, Grant, Busy, Trunc_Err
    );
endinterface

// File: rtl/eth_tx_arbiter.sv
// eth_tx_arbiter: round-robin whole-packet arbiter feeding eth_packet_former from two byte sources,
// capping payload length and holding off the next grant for the inter-frame gap.
module eth_tx_arbiter #(
    parameter int pMAX_BYTES  = 72,
    parameter int pIFG_CYCLES = 48
) (
    input logic              Clk,
    input logic              Rst,
    eth_tx_arbiter_if.master bus
);
    localparam int                 cIfgW    = $clog2(pIFG_CYCLES + 1);
    localparam logic [9:0]         cCapLast = 10'(pMAX_BYTES - 1);
    localparam logic [cIfgW-1:0]   cIfgLast = cIfgW'(pIFG_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, XFER, DRAIN, WAIT_TX, IFG} state_t;

    state_t           state, nextState;
    logic [1:0]       grant, nextGrant;
    logic             lastGrant, nextLastGrant;
    logic [9:0]       byteCnt, nextByteCnt;
    logic [cIfgW-1:0] ifgCnt, nextIfgCnt;
    logic             txSeen, nextTxSeen;
    logic             truncErr, nextTrunc;
    logic             sValid, sLast, srcReady, datEn, dataLast, capHit, pickS1;
    logic [7:0]       sData;

    assign sValid   = grant[1] ? bus.S1_Valid : bus.S0_Valid;
    assign sLast    = grant[1] ? bus.S1_Last  : bus.S0_Last;
    assign sData    = grant[1] ? bus.S1_Data  : bus.S0_Data;
    // DRAIN swallows the overflow tail of a truncated packet without forwarding it
    assign srcReady = (state == XFER) ? bus.Dat_Rdy : (state == DRAIN);
    assign capHit   = byteCnt == cCapLast;
    assign datEn    = (state == XFER) & sValid & bus.Dat_Rdy;
    assign dataLast = datEn & (sLast | capHit);
    // on contention the source that did not own the previous packet wins
    assign pickS1   = (bus.S0_Valid & bus.S1_Valid) ? ~lastGrant : bus.S1_Valid;

    assign bus.S0_Ready  = srcReady & grant[0];
    assign bus.S1_Ready  = srcReady & grant[1];
    assign bus.Dat_En    = datEn;
    assign bus.Data      = (state == XFER) ? sData : 8'h00;
    assign bus.Data_Last = dataLast;
    assign bus.Grant     = grant;
    assign bus.Busy      = state != IDLE;
    assign bus.Trunc_Err = truncErr;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state     <= IDLE;
            grant     <= 2'b00;
            lastGrant <= 1'b1;
            byteCnt   <= '0;
            ifgCnt    <= '0;
            txSeen    <= 1'b0;
            truncErr  <= 1'b0;
        end else begin
            state     <= nextState;
            grant     <= nextGrant;
            lastGrant <= nextLastGrant;
            byteCnt   <= nextByteCnt;
            ifgCnt    <= nextIfgCnt;
            txSeen    <= nextTxSeen;
            truncErr  <= nextTrunc;
        end
    end

    always_comb begin
        nextState     = state;
        nextGrant     = grant;
        nextLastGrant = lastGrant;
        nextByteCnt   = byteCnt;
        nextIfgCnt    = ifgCnt;
        nextTrunc     = 1'b0;
        // the former's transmission only counts once the final byte has been handed over
        nextTxSeen    = txSeen | (bus.Tx_En & (dataLast | state == DRAIN | state == WAIT_TX));
        case (state)
            IDLE: begin
                if (bus.S0_Valid | bus.S1_Valid) begin
                    nextGrant     = pickS1 ? 2'b10 : 2'b01;
                    nextLastGrant = pickS1;
                    nextByteCnt   = '0;
                    nextState     = XFER;
                end
            end
            XFER: begin
                if (datEn) begin
                    nextByteCnt = byteCnt + 10'd1;
                    if (sLast) begin
                        nextState = WAIT_TX;
                    end else if (capHit) begin
                        nextState = DRAIN;
                        nextTrunc = 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (sValid & sLast) nextState = WAIT_TX;
            end
            WAIT_TX: begin
                if (txSeen & ~bus.Tx_En) begin
                    nextState  = IFG;
                    nextIfgCnt = '0;
                    nextGrant  = 2'b00;
                end
            end
            IFG: begin
                nextIfgCnt = ifgCnt + 1'b1;
                if (ifgCnt == cIfgLast) begin
                    nextState  = IDLE;
                    nextTxSeen = 1'b0;
                end
            end
            default: nextState = IDLE;
        endcase
    end
endmodule
